// File: rtl/drive_pkg.sv
// Shared types and constants for the drive command arbiter.
//   cmd_e       : 3-bit drive command code from the IR/UART sources
//   state_e     : 2-bit sequencer state
//   OWN_*       : command-source ownership encoding
//   DIR_*       : per-motor {ina,inb} bridge encodings
//   cmd_to_dir  : command -> {dir1,dir2}
//   cmd_is_valid: codes 6 and 7 are not commands
package drive_pkg;

  typedef enum logic [2:0] {
    CMD_NONE  = 3'd0,
    CMD_FWD   = 3'd1,
    CMD_LEFT  = 3'd2,
    CMD_BRAKE = 3'd3,
    CMD_RIGHT = 3'd4,
    CMD_BACK  = 3'd5
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DWELL = 2'd2
  } state_e;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_IR   = 2'd1;
  localparam logic [1:0] OWN_UART = 2'd2;

  localparam logic [1:0] DIR_FWD   = 2'b10;
  localparam logic [1:0] DIR_REV   = 2'b01;
  localparam logic [1:0] DIR_BRAKE = 2'b11;
  localparam logic [1:0] DIR_COAST = 2'b00;

  function automatic logic [3:0] cmd_to_dir(input cmd_e c);
    case (c)
      CMD_FWD:   return {DIR_FWD, DIR_FWD};
      CMD_BACK:  return {DIR_REV, DIR_REV};
      CMD_LEFT:  return {DIR_REV, DIR_FWD};
      CMD_RIGHT: return {DIR_FWD, DIR_REV};
      CMD_BRAKE: return {DIR_BRAKE, DIR_BRAKE};
      default:   return {DIR_COAST, DIR_COAST};
    endcase
  endfunction

  function automatic logic cmd_is_valid(input logic [2:0] c);
    return (c <= 3'd5);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Scheduler tick generator: counts 0..CLKS_PER_TICK-1 and pulses tick for
// the single cycle in which the counter wraps.
//   clk   : system clock
//   reset : synchronous, active-high
//   tick  : one-cycle pulse every CLKS_PER_TICK cycles
module tick_prescaler #(
  parameter int CLKS_PER_TICK = 500_000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_TICK - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset)                  r_cnt <= '0;
    else if (r_cnt == CNT_LAST) r_cnt <= '0;
    else                        r_cnt <= r_cnt + 1'b1;
  end

  assign tick = (r_cnt == CNT_LAST);

endmodule

// File: rtl/drive_cmd_arbiter.sv
// Drive command arbiter: picks IR/UART commands under source ownership,
// applies the proximity forward-stop override, and sequences the dual motor
// bridge through run (duty ramp), brake dwell and idle with a deadman timeout.
//   clk, reset            : system clock, synchronous active-high reset
//   ir_valid/ir_cmd       : IR decoder command pulse
//   uart_valid/uart_cmd   : UART receiver command pulse
//   prox_level            : proximity level, 15 = nearest
//   dir1/dir2, duty1/duty2: registered motor bridge controls
//   motor_stat, owner, prox_block, state : registered status
// Build option DRIVE_ARB_SOFTSTART_EN: when defined duty ramps by RAMP_STEP
// per tick from 0; when undefined duty is DUTY_MAX from the first RUN cycle.
//
// state    | meaning
// ST_IDLE  | bridge coasting, no owner
// ST_RUN   | driving r_cmd, ramping duty, deadman timer running
// ST_DWELL | bridge braked for DWELL_TICKS, optional pending command
module drive_cmd_arbiter
  import drive_pkg::*;
#(
  parameter int CLKS_PER_TICK = 500_000,
  parameter int DUTY_MAX      = 20,
  parameter int RAMP_STEP     = 2,
  parameter int TIMEOUT_TICKS = 50,
  parameter int DWELL_TICKS   = 20,
  parameter int PROX_STOP     = 12,
  parameter int PROX_HYST     = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ir_valid,
  input  logic [2:0] ir_cmd,
  input  logic       uart_valid,
  input  logic [2:0] uart_cmd,
  input  logic [3:0] prox_level,
  output logic [1:0] dir1,
  output logic [1:0] dir2,
  output logic [6:0] duty1,
  output logic [6:0] duty2,
  output logic [2:0] motor_stat,
  output logic [1:0] owner,
  output logic       prox_block,
  output logic [1:0] state
);

  localparam int TW = $clog2(TIMEOUT_TICKS + 1);
  localparam int DW = $clog2(DWELL_TICKS + 1);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_TICKS - 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_TICKS - 1);
  localparam logic [6:0]    DUTY_FULL  = 7'(DUTY_MAX);
  localparam logic [4:0]    PROX_SET   = 5'(PROX_STOP);
  localparam logic [4:0]    PROX_CLR   = 5'(PROX_STOP - PROX_HYST);

  state_e        r_state, w_state_nxt;
  cmd_e          r_cmd, w_run_cmd;
  cmd_e          r_pend, w_pend_nxt;
  cmd_e          r_stat, w_stat_nxt;
  logic [1:0]    r_owner, w_owner_nxt;
  logic [6:0]    r_duty, w_duty_nxt;
  logic [TW-1:0] r_tmo, w_tmo_nxt;
  logic [DW-1:0] r_dwell, w_dwell_nxt;
  logic [3:0]    r_dir, w_dir_nxt;
  logic          r_prox_block, w_prox_nxt;

  logic w_tick;
  tick_prescaler #(.CLKS_PER_TICK(CLKS_PER_TICK)) u_tick (
    .clk  (clk),
    .reset(reset),
    .tick (w_tick)
  );

  // Arbitration
  cmd_e       w_ir_cmd, w_uart_cmd, w_sel_cmd, w_eff_cmd;
  logic       w_ir_ok, w_uart_ok, w_acc, w_brake, w_motion;
  logic [1:0] w_src;

  assign w_ir_cmd   = cmd_e'(ir_cmd);
  assign w_uart_cmd = cmd_e'(uart_cmd);
  assign w_ir_ok    = ir_valid && cmd_is_valid(ir_cmd) &&
                      (w_ir_cmd == CMD_BRAKE || r_owner == OWN_NONE || r_owner == OWN_IR);
  assign w_uart_ok  = uart_valid && cmd_is_valid(uart_cmd) &&
                      (w_uart_cmd == CMD_BRAKE || r_owner == OWN_NONE || r_owner == OWN_UART);

  always_comb begin
    w_acc     = 1'b0;
    w_src     = OWN_NONE;
    w_sel_cmd = CMD_NONE;
    // UART wins a tie unless IR is braking
    if (w_uart_ok && !(w_ir_ok && w_ir_cmd == CMD_BRAKE)) begin
      w_acc     = 1'b1;
      w_src     = OWN_UART;
      w_sel_cmd = w_uart_cmd;
    end else if (w_ir_ok) begin
      w_acc     = 1'b1;
      w_src     = OWN_IR;
      w_sel_cmd = w_ir_cmd;
    end
  end

  // Hysteretic block; the next value is used so the override acts in the
  // same cycle the level crosses the threshold.
  always_comb begin
    w_prox_nxt = r_prox_block;
    if ({1'b0, prox_level} >= PROX_SET)     w_prox_nxt = 1'b1;
    else if ({1'b0, prox_level} < PROX_CLR) w_prox_nxt = 1'b0;
  end

  assign w_eff_cmd = (w_sel_cmd == CMD_FWD && w_prox_nxt) ? CMD_BRAKE : w_sel_cmd;
  assign w_brake   = w_acc && (w_eff_cmd == CMD_BRAKE);
  assign w_motion  = w_acc && (w_eff_cmd != CMD_NONE) && (w_eff_cmd != CMD_BRAKE);

`ifdef DRIVE_ARB_SOFTSTART_EN
  localparam logic [6:0] DUTY_START = 7'd0;
  logic [7:0] w_duty_sum;
  assign w_duty_sum = {1'b0, r_duty} + 8'(RAMP_STEP);
`else
  localparam logic [6:0] DUTY_START = DUTY_FULL;
  // Ramp step has no effect when duty starts at full scale.
  logic [7:0] w_unused_ramp_step;
  assign w_unused_ramp_step = 8'(RAMP_STEP);
`endif

  logic w_go_dwell, w_go_run, w_go_idle;

  always_comb begin
    w_go_dwell  = 1'b0;
    w_go_run    = 1'b0;
    w_go_idle   = 1'b0;
    w_run_cmd   = r_cmd;
    w_pend_nxt  = r_pend;
    w_tmo_nxt   = r_tmo;
    w_dwell_nxt = r_dwell;
    w_duty_nxt  = r_duty;
    w_state_nxt = r_state;

    case (r_state)
      ST_IDLE: begin
        if (w_brake) begin
          w_go_dwell = 1'b1;
          w_pend_nxt = CMD_NONE;
        end else if (w_motion) begin
          w_go_run  = 1'b1;
          w_run_cmd = w_eff_cmd;
        end
      end
      ST_RUN: begin
        if (w_tick) begin
          w_tmo_nxt = r_tmo + 1'b1;
`ifdef DRIVE_ARB_SOFTSTART_EN
          w_duty_nxt = (w_duty_sum >= {1'b0, DUTY_FULL}) ? DUTY_FULL : w_duty_sum[6:0];
`endif
        end
        if (w_brake || (r_cmd == CMD_FWD && w_prox_nxt)) begin
          w_go_dwell = 1'b1;
          w_pend_nxt = CMD_NONE;
        end else if (w_motion && w_eff_cmd != r_cmd) begin
          w_go_dwell = 1'b1;
          w_pend_nxt = w_eff_cmd;
        end else if (w_acc) begin
          w_tmo_nxt = '0;
        end else if (w_tick && r_tmo == TMO_LAST) begin
          w_go_dwell = 1'b1;
          w_pend_nxt = CMD_NONE;
        end
      end
      ST_DWELL: begin
        if (w_brake)       w_pend_nxt = CMD_NONE;
        else if (w_motion) w_pend_nxt = w_eff_cmd;
        if (w_tick) begin
          if (r_dwell == DWELL_LAST) begin
            // A pending forward move is dropped if the path is now blocked.
            if (w_pend_nxt != CMD_NONE && !(w_pend_nxt == CMD_FWD && w_prox_nxt)) begin
              w_go_run  = 1'b1;
              w_run_cmd = w_pend_nxt;
            end else begin
              w_go_idle = 1'b1;
            end
          end else begin
            w_dwell_nxt = r_dwell + 1'b1;
          end
        end
      end
      default: w_go_idle = 1'b1;
    endcase

    if (w_go_dwell) begin
      w_state_nxt = ST_DWELL;
      w_dwell_nxt = '0;
      w_duty_nxt  = '0;
    end else if (w_go_run) begin
      w_state_nxt = ST_RUN;
      w_tmo_nxt   = '0;
      w_pend_nxt  = CMD_NONE;
      w_duty_nxt  = DUTY_START;
    end else if (w_go_idle) begin
      w_state_nxt = ST_IDLE;
      w_pend_nxt  = CMD_NONE;
      w_duty_nxt  = '0;
    end
  end

  always_comb begin
    w_owner_nxt = r_owner;
    if (w_go_idle)                           w_owner_nxt = OWN_NONE;
    else if (w_acc && w_eff_cmd != CMD_NONE) w_owner_nxt = w_src;
  end

  always_comb begin
    w_dir_nxt  = {DIR_COAST, DIR_COAST};
    w_stat_nxt = CMD_NONE;
    case (w_state_nxt)
      ST_RUN: begin
        w_dir_nxt  = cmd_to_dir(w_run_cmd);
        w_stat_nxt = w_run_cmd;
      end
      ST_DWELL: begin
        w_dir_nxt  = {DIR_BRAKE, DIR_BRAKE};
        w_stat_nxt = CMD_BRAKE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_cmd        <= CMD_NONE;
      r_pend       <= CMD_NONE;
      r_stat       <= CMD_NONE;
      r_owner      <= OWN_NONE;
      r_duty       <= '0;
      r_tmo        <= '0;
      r_dwell      <= '0;
      r_dir        <= {DIR_COAST, DIR_COAST};
      r_prox_block <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cmd        <= w_run_cmd;
      r_pend       <= w_pend_nxt;
      r_stat       <= w_stat_nxt;
      r_owner      <= w_owner_nxt;
      r_duty       <= w_duty_nxt;
      r_tmo        <= w_tmo_nxt;
      r_dwell      <= w_dwell_nxt;
      r_dir        <= w_dir_nxt;
      r_prox_block <= w_prox_nxt;
    end
  end

  assign dir1       = r_dir[3:2];
  assign dir2       = r_dir[1:0];
  assign duty1      = r_duty;
  assign duty2      = r_duty;
  assign motor_stat = r_stat;
  assign owner      = r_owner;
  assign prox_block = r_prox_block;
  assign state      = r_state;

endmodule

// File: tb/tb_drive_cmd_arbiter.sv
// Directed bench for drive_cmd_arbiter with a 4-cycle tick.
module tb_drive_cmd_arbiter;
  import drive_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ir_valid = 1'b0;
  logic [2:0] ir_cmd = 3'd0;
  logic       uart_valid = 1'b0;
  logic [2:0] uart_cmd = 3'd0;
  logic [3:0] prox_level = 4'd0;
  logic [1:0] dir1, dir2, owner, state;
  logic [6:0] duty1, duty2;
  logic [2:0] motor_stat;
  logic       prox_block;

  int n_checks = 0;
  int n_errors = 0;
  int tb_pcnt = 0;

  drive_cmd_arbiter #(
    .CLKS_PER_TICK(4), .DUTY_MAX(20), .RAMP_STEP(4), .TIMEOUT_TICKS(10),
    .DWELL_TICKS(3), .PROX_STOP(12), .PROX_HYST(2)
  ) dut (
    .clk(clk), .reset(reset),
    .ir_valid(ir_valid), .ir_cmd(ir_cmd),
    .uart_valid(uart_valid), .uart_cmd(uart_cmd),
    .prox_level(prox_level),
    .dir1(dir1), .dir2(dir2), .duty1(duty1), .duty2(duty2),
    .motor_stat(motor_stat), .owner(owner), .prox_block(prox_block), .state(state)
  );

  always #5 clk = ~clk;

  // Reference tick: period 4, tick at the edge leaving count 3.
  always @(posedge clk) begin
    if (reset) tb_pcnt <= 0;
    else       tb_pcnt <= (tb_pcnt == 3) ? 0 : tb_pcnt + 1;
  end

  function automatic logic [6:0] exp_duty(input int k);
`ifdef DRIVE_ARB_SOFTSTART_EN
    return (4 * k > 20) ? 7'd20 : 7'(4 * k);
`else
    return 7'd20;
`endif
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ticks(input int n);
    int seen = 0;
    while (seen < n) begin
      if (tb_pcnt == 3) seen++;
      cyc();
    end
  endtask

  task automatic send_uart(input logic [2:0] c);
    uart_valid = 1'b1; uart_cmd = c;
    cyc();
    uart_valid = 1'b0; uart_cmd = 3'd0;
  endtask

  task automatic send_ir(input logic [2:0] c);
    ir_valid = 1'b1; ir_cmd = c;
    cyc();
    ir_valid = 1'b0; ir_cmd = 3'd0;
  endtask

  task automatic send_both(input logic [2:0] ic, input logic [2:0] uc);
    ir_valid = 1'b1; ir_cmd = ic; uart_valid = 1'b1; uart_cmd = uc;
    cyc();
    ir_valid = 1'b0; ir_cmd = 3'd0; uart_valid = 1'b0; uart_cmd = 3'd0;
  endtask

  task automatic test_reset();
    logic [21:0] got;
    reset = 1'b1;
    repeat (3) cyc();
    got = {state, dir1, dir2, duty1, duty2, motor_stat, owner, prox_block};
    n_checks++;
    if (got !== 22'd0) begin
      n_errors++; $display("FAIL reset_values: got %h expected 0", got);
    end
    reset = 1'b0;
    cyc();
    n_checks++;
    if ({state, owner, dir1, dir2} !== 8'd0) begin
      n_errors++; $display("FAIL reset_release_idle: got %h expected 0", {state, owner, dir1, dir2});
    end
  endtask

  task automatic test_fwd_ramp();
    send_uart(CMD_FWD);
    n_checks++;
    if ({state, dir1, dir2, owner, motor_stat} !== {2'd1, 2'b10, 2'b10, 2'd2, 3'd1}) begin
      n_errors++; $display("FAIL fwd_start: got %h expected %h",
        {state, dir1, dir2, owner, motor_stat}, {2'd1, 2'b10, 2'b10, 2'd2, 3'd1});
    end
    n_checks++;
    if ({duty1, duty2} !== {exp_duty(0), exp_duty(0)}) begin
      n_errors++; $display("FAIL fwd_duty0: got %0d/%0d expected %0d", duty1, duty2, exp_duty(0));
    end
    for (int k = 1; k <= 6; k++) begin
      wait_ticks(1);
      n_checks++;
      if ({duty1, duty2} !== {exp_duty(k), exp_duty(k)}) begin
        n_errors++; $display("FAIL fwd_ramp_tick%0d: got %0d/%0d expected %0d", k, duty1, duty2, exp_duty(k));
      end
    end
  endtask

  task automatic test_owner_lock();
    send_ir(CMD_LEFT);
    n_checks++;
    if ({state, dir1, dir2, owner, motor_stat, duty1} !== {2'd1, 2'b10, 2'b10, 2'd2, 3'd1, 7'd20}) begin
      n_errors++; $display("FAIL ir_left_ignored: got %h", {state, dir1, dir2, owner, motor_stat, duty1});
    end
    send_ir(CMD_BRAKE);
    n_checks++;
    if ({state, dir1, dir2, duty1, duty2, motor_stat, owner} !== {2'd2, 2'b11, 2'b11, 7'd0, 7'd0, 3'd3, 2'd1}) begin
      n_errors++; $display("FAIL ir_brake_dwell: got %h", {state, dir1, dir2, duty1, duty2, motor_stat, owner});
    end
    wait_ticks(2);
    n_checks++;
    if (state !== 2'd2) begin
      n_errors++; $display("FAIL dwell_hold: got state %0d expected 2", state);
    end
    wait_ticks(1);
    n_checks++;
    if ({state, owner, dir1, dir2, motor_stat, duty1} !== 16'd0) begin
      n_errors++; $display("FAIL dwell_to_idle: got %h expected 0", {state, owner, dir1, dir2, motor_stat, duty1});
    end
  endtask

  task automatic test_reversal();
    send_uart(CMD_FWD);
    wait_ticks(5);
    n_checks++;
    if (duty1 !== 7'd20) begin
      n_errors++; $display("FAIL rev_pre_duty: got %0d expected 20", duty1);
    end
    send_uart(CMD_BACK);
    n_checks++;
    if ({state, dir1, dir2, motor_stat, duty1} !== {2'd2, 2'b11, 2'b11, 3'd3, 7'd0}) begin
      n_errors++; $display("FAIL rev_dwell: got %h", {state, dir1, dir2, motor_stat, duty1});
    end
    wait_ticks(2);
    n_checks++;
    if (state !== 2'd2) begin
      n_errors++; $display("FAIL rev_dwell_hold: got state %0d expected 2", state);
    end
    wait_ticks(1);
    n_checks++;
    if ({state, dir1, dir2, motor_stat, owner, duty1} !== {2'd1, 2'b01, 2'b01, 3'd5, 2'd2, exp_duty(0)}) begin
      n_errors++; $display("FAIL rev_run_back: got %h expected %h",
        {state, dir1, dir2, motor_stat, owner, duty1}, {2'd1, 2'b01, 2'b01, 3'd5, 2'd2, exp_duty(0)});
    end
    wait_ticks(1);
    n_checks++;
    if (duty1 !== exp_duty(1)) begin
      n_errors++; $display("FAIL rev_ramp: got %0d expected %0d", duty1, exp_duty(1));
    end
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 4; i++) begin
      wait_ticks(5);
      send_uart(CMD_NONE);
      n_checks++;
      if ({state, motor_stat} !== {2'd1, 3'd5}) begin
        n_errors++; $display("FAIL keepalive_%0d: got state %0d stat %0d expected 1/5", i, state, motor_stat);
      end
    end
    wait_ticks(9);
    n_checks++;
    if (state !== 2'd1) begin
      n_errors++; $display("FAIL timeout_early: got state %0d expected 1", state);
    end
    wait_ticks(1);
    n_checks++;
    if ({state, motor_stat} !== {2'd2, 3'd3}) begin
      n_errors++; $display("FAIL timeout_dwell: got state %0d stat %0d expected 2/3", state, motor_stat);
    end
    wait_ticks(3);
    n_checks++;
    if ({state, owner} !== 4'd0) begin
      n_errors++; $display("FAIL timeout_idle: got state %0d owner %0d expected 0/0", state, owner);
    end
  endtask

  task automatic test_prox();
    prox_level = 4'd11;
    cyc();
    send_uart(CMD_FWD);
    n_checks++;
    if ({prox_block, state, motor_stat} !== {1'b0, 2'd1, 3'd1}) begin
      n_errors++; $display("FAIL prox11_fwd: got %h", {prox_block, state, motor_stat});
    end
    prox_level = 4'd12;
    cyc();
    n_checks++;
    if ({prox_block, state, dir1, dir2, motor_stat} !== {1'b1, 2'd2, 2'b11, 2'b11, 3'd3}) begin
      n_errors++; $display("FAIL prox12_stop: got %h", {prox_block, state, dir1, dir2, motor_stat});
    end
    wait_ticks(3);
    send_uart(CMD_FWD);
    n_checks++;
    if ({state, motor_stat, owner} !== {2'd2, 3'd3, 2'd2}) begin
      n_errors++; $display("FAIL prox_fwd_as_brake: got %h expected %h", {state, motor_stat, owner}, {2'd2, 3'd3, 2'd2});
    end
    wait_ticks(3);
    send_uart(CMD_BACK);
    n_checks++;
    if ({state, dir1, dir2, motor_stat} !== {2'd1, 2'b01, 2'b01, 3'd5}) begin
      n_errors++; $display("FAIL prox_back_ok: got %h", {state, dir1, dir2, motor_stat});
    end
    prox_level = 4'd10;
    cyc();
    n_checks++;
    if ({prox_block, state} !== {1'b1, 2'd1}) begin
      n_errors++; $display("FAIL prox10_hold: got block %0d state %0d expected 1/1", prox_block, state);
    end
    prox_level = 4'd9;
    cyc();
    n_checks++;
    if (prox_block !== 1'b0) begin
      n_errors++; $display("FAIL prox9_release: got %0d expected 0", prox_block);
    end
    send_uart(CMD_FWD);
    wait_ticks(3);
    n_checks++;
    if ({state, dir1, dir2, motor_stat} !== {2'd1, 2'b10, 2'b10, 3'd1}) begin
      n_errors++; $display("FAIL prox_fwd_after_release: got %h", {state, dir1, dir2, motor_stat});
    end
    send_uart(CMD_BRAKE);
    wait_ticks(3);
    prox_level = 4'd0;
  endtask

  task automatic test_simultaneous();
    send_both(CMD_FWD, CMD_RIGHT);
    n_checks++;
    if ({state, dir1, dir2, owner, motor_stat} !== {2'd1, 2'b10, 2'b01, 2'd2, 3'd4}) begin
      n_errors++; $display("FAIL both_uart_wins: got %h", {state, dir1, dir2, owner, motor_stat});
    end
    send_both(CMD_BRAKE, CMD_FWD);
    n_checks++;
    if ({state, dir1, dir2, owner, motor_stat} !== {2'd2, 2'b11, 2'b11, 2'd1, 3'd3}) begin
      n_errors++; $display("FAIL both_ir_brake_wins: got %h", {state, dir1, dir2, owner, motor_stat});
    end
    wait_ticks(3);
    send_uart(3'd7);
    n_checks++;
    if ({state, owner, motor_stat} !== 7'd0) begin
      n_errors++; $display("FAIL cmd7_idle_ignored: got %h expected 0", {state, owner, motor_stat});
    end
    send_ir(CMD_LEFT);
    send_uart(CMD_FWD);
    n_checks++;
    if ({state, dir1, dir2, owner, motor_stat} !== {2'd1, 2'b01, 2'b10, 2'd1, 3'd2}) begin
      n_errors++; $display("FAIL uart_locked_out: got %h", {state, dir1, dir2, owner, motor_stat});
    end
    send_ir(CMD_LEFT);
    wait_ticks(5);
    send_ir(3'd7);
    wait_ticks(4);
    n_checks++;
    if (state !== 2'd1) begin
      n_errors++; $display("FAIL cmd7_pre_timeout: got state %0d expected 1", state);
    end
    wait_ticks(1);
    n_checks++;
    if (state !== 2'd2) begin
      n_errors++; $display("FAIL cmd7_no_refresh: got state %0d expected 2", state);
    end
    wait_ticks(3);
    send_uart(CMD_RIGHT);
    reset = 1'b1;
    cyc();
    n_checks++;
    if ({state, dir1, dir2, duty1, duty2, motor_stat, owner, prox_block} !== 22'd0) begin
      n_errors++; $display("FAIL reset_mid_run: got %h expected 0",
        {state, dir1, dir2, duty1, duty2, motor_stat, owner, prox_block});
    end
    reset = 1'b0;
    cyc();
  endtask

  initial begin
    test_reset();
    test_fwd_ramp();
    test_owner_lock();
    test_reversal();
    test_timeout();
    test_prox();
    test_simultaneous();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
